result_wr_arb: RTL and testbench
================================

RESULT_WR_ARB -- requirements
Module: result_wr_arb

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning the number of result batch buffers served.
REQ-002 SHALL have parameter LINE_ADDR_WIDTH, default 8, meaning the per-buffer line index width (256 lines per batch).
REQ-003 SHALL have parameter DATA_WIDTH, default 512, meaning the cache-line width.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 32, meaning the memory line-address width.
REQ-005 SHALL have parameter ACK_GAP, default 2, meaning the idle cycles after each ack before a source's line/data are sampled again.
REQ-006 SHALL have ports, in this order:
- clk  in  1  core clock; one clock only.
- reset  in  1  reset; asynchronous, active-high.
- rbb_req_valid  in  NUM_PE  per-buffer "line available".
- rbb_req_line_idx  in  NUM_PE*LINE_ADDR_WIDTH  per-buffer line index; buffer k at slice k.
- rbb_req_data  in  NUM_PE*DATA_WIDTH  per-buffer line data; buffer k at slice k.
- rbb_req_ack  out  NUM_PE  one-cycle consume pulse per buffer.
- result_base_addr  in  MEM_ADDR_WIDTH  line address of the result region.
- wr_almost_full  in  1  downstream write channel cannot accept.
- wr_req_valid  out  1  one-cycle write-request pulse.
- wr_req_addr  out  MEM_ADDR_WIDTH  write line address.
- wr_req_data  out  DATA_WIDTH  write data.
- batch_done  out  NUM_PE  one-cycle pulse when buffer k's last line is issued.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-007 SHALL use states IDLE, ISSUE and GAP.
REQ-008 IDLE: on any rbb_req_valid high, SHALL latch the granted index g (round-robin, see REQ-009) and enter ISSUE the next cycle.
REQ-009 Round-robin grant SHALL search from priority pointer p upward, modulo NUM_PE; p SHALL become (g+1) mod NUM_PE when the batch of g completes.
REQ-010 The grant SHALL be held for the whole batch; no other buffer SHALL be acked until g's line NUM_LINES-1 is issued.
REQ-011 ISSUE: when rbb_req_valid[g]=1 and wr_almost_full=0, SHALL register the following, assert them together for exactly one cycle, then enter GAP:
- wr_req_valid=1
- wr_req_data = data slice g
- wr_req_addr = result_base_addr + (g << LINE_ADDR_WIDTH) + line_idx slice g, modulo 2^MEM_ADDR_WIDTH
- rbb_req_ack[g]=1
REQ-012 ISSUE: when wr_almost_full=1 or rbb_req_valid[g]=0, SHALL hold with no request and no ack; no timeout.
REQ-013 GAP SHALL last exactly ACK_GAP cycles, counted by a down-counter loaded at the issue cycle.
REQ-014 At GAP end, SHALL enter IDLE if the issued line index was 2^LINE_ADDR_WIDTH-1, else ISSUE.
REQ-015 batch_done[g] SHALL pulse one cycle in the same cycle as the wr_req_valid of line index 2^LINE_ADDR_WIDTH-1.
REQ-016 Throughput SHALL be one line per ACK_GAP+1 cycles when unstalled; latency from rbb_req_valid in IDLE to the first wr_req_valid SHALL be 2 cycles.
REQ-017 At most one rbb_req_ack bit SHALL be high in any cycle; rbb_req_ack and wr_req_valid SHALL always coincide.
REQ-018 wr_req_addr/wr_req_data SHALL hold their last values when wr_req_valid=0.
REQ-019 result_base_addr SHALL be sampled at each issue cycle (no latching per batch).
REQ-020 A valid drop of the granted buffer mid-batch SHALL NOT release the grant.

Reset
REQ-021 reset high SHALL asynchronously force:
- state=IDLE, p=0, g=0, GAP counter=0
- wr_req_valid=0, rbb_req_ack=0, batch_done=0, busy=0
- wr_req_addr=0, wr_req_data=0
REQ-022 Reset mid-batch SHALL abandon the batch with no further ack; after release, operation SHALL restart from REQ-008 with p=0.

Verification
REQ-023 Single buffer: valid[0]=1, lines 0..255, base=0x1000 -> 256 pulses, addr 0x1000..0x10FF, 3-cycle spacing, batch_done[0] with addr 0x10FF.
REQ-024 Contention: valid[1] and valid[3] both high from IDLE, p=0 -> full batch of 1 (addr base+0x100..), then batch of 3 (base+0x300..); p ends at 0.
REQ-025 Backpressure: wr_almost_full=1 for 10 cycles during ISSUE -> no wr_req_valid/ack for those cycles; the next line issues the cycle after deassertion, no line lost or duplicated.
REQ-026 Wrap: base=0xFFFFFF80, g=0 -> line 0x80 addressed 0x00000000.
REQ-027 Reset asserted in GAP at line 37 -> all outputs 0 immediately; after release with valid[2]=1, first grant to buffer 2 after 2 cycles.
REQ-028 Checker: every cycle, popcount(rbb_req_ack)<=1 and rbb_req_ack!=0 iff wr_req_valid=1.

Source files
------------

// File: rtl/result_wr_arb.sv
// Round-robin write arbiter: drains one result batch buffer at a time into the memory write
// channel, one line per ACK_GAP+1 cycles, holding the grant until the batch's last line issues.
module result_wr_arb #(
  parameter int NUM_PE          = 4,
  parameter int LINE_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 512,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int ACK_GAP         = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PE-1:0]                   rbb_req_valid,
  input  logic [NUM_PE*LINE_ADDR_WIDTH-1:0]   rbb_req_line_idx,
  input  logic [NUM_PE*DATA_WIDTH-1:0]        rbb_req_data,
  output logic [NUM_PE-1:0]                   rbb_req_ack,
  input  logic [MEM_ADDR_WIDTH-1:0]           result_base_addr,
  input  logic                                wr_almost_full,
  output logic                                wr_req_valid,
  output logic [MEM_ADDR_WIDTH-1:0]           wr_req_addr,
  output logic [DATA_WIDTH-1:0]               wr_req_data,
  output logic [NUM_PE-1:0]                   batch_done,
  output logic                                busy
);

  localparam int GW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = (ACK_GAP > 1) ? $clog2(ACK_GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e                      state;
  logic [GW-1:0]               prioPtr;
  logic [GW-1:0]               grantIdx;
  logic [CW-1:0]               gapCnt;
  logic                        lastIssued;

  logic [GW-1:0]               rrGrant;
  logic                        rrFound;
  int                          cand;
  logic                        selValid;
  logic [LINE_ADDR_WIDTH-1:0]  selLine;
  logic [DATA_WIDTH-1:0]       selData;
  logic [MEM_ADDR_WIDTH-1:0]   selAddr;
  logic                        selLast;
  logic [GW-1:0]               nextPtr;

  // First requesting buffer at or above the priority pointer, wrapping around.
  always_comb begin
    rrFound = 1'b0;
    rrGrant = prioPtr;
    cand    = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      cand = (int'(prioPtr) + i) % NUM_PE;
      if (!rrFound && rbb_req_valid[cand]) begin
        rrFound = 1'b1;
        rrGrant = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    selValid = rbb_req_valid[grantIdx];
    selLine  = rbb_req_line_idx[int'(grantIdx)*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
    selData  = rbb_req_data[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
    selAddr  = result_base_addr + (MEM_ADDR_WIDTH'(grantIdx) << LINE_ADDR_WIDTH)
               + MEM_ADDR_WIDTH'(selLine);
    selLast  = &selLine;
    nextPtr  = (grantIdx == GW'(NUM_PE - 1)) ? '0 : grantIdx + GW'(1);
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      prioPtr      <= '0;
      grantIdx     <= '0;
      gapCnt       <= '0;
      lastIssued   <= 1'b0;
      wr_req_valid <= 1'b0;
      rbb_req_ack  <= '0;
      batch_done   <= '0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      wr_req_valid <= 1'b0;
      rbb_req_ack  <= '0;
      batch_done   <= '0;
      unique case (state)
        StIdle: begin
          if (rrFound) begin
            grantIdx <= rrGrant;
            state    <= StIssue;
          end
        end
        StIssue: begin
          // Stall indefinitely on backpressure or a missing line; the grant is never released.
          if (selValid && !wr_almost_full) begin
            wr_req_valid          <= 1'b1;
            wr_req_addr           <= selAddr;
            wr_req_data           <= selData;
            rbb_req_ack[grantIdx] <= 1'b1;
            batch_done[grantIdx]  <= selLast;
            lastIssued            <= selLast;
            gapCnt                <= CW'(ACK_GAP);
            if (selLast) prioPtr <= nextPtr;
            if (ACK_GAP == 0) state <= selLast ? StIdle : StIssue;
            else              state <= StGap;
          end
        end
        StGap: begin
          if (gapCnt <= CW'(1)) begin
            gapCnt <= '0;
            state  <= lastIssued ? StIdle : StIssue;
          end else begin
            gapCnt <= gapCnt - CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_wr_arb.sv
// Directed bench for result_wr_arb: a vector table of single-line batches plus hand-written
// sequences for full batches, contention, backpressure, address wrap and mid-batch reset.
module tb_result_wr_arb;

  localparam int NPE = 4;
  localparam int LW  = 8;
  localparam int DW  = 512;
  localparam int AW  = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [NPE-1:0]      rbb_req_valid;
  logic [NPE*LW-1:0]   rbb_req_line_idx;
  logic [NPE*DW-1:0]   rbb_req_data;
  logic [NPE-1:0]      rbb_req_ack;
  logic [AW-1:0]       result_base_addr;
  logic                wr_almost_full;
  logic                wr_req_valid;
  logic [AW-1:0]       wr_req_addr;
  logic [DW-1:0]       wr_req_data;
  logic [NPE-1:0]      batch_done;
  logic                busy;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  result_wr_arb dut (
    .clk              (clk),
    .reset            (reset),
    .rbb_req_valid    (rbb_req_valid),
    .rbb_req_line_idx (rbb_req_line_idx),
    .rbb_req_data     (rbb_req_data),
    .rbb_req_ack      (rbb_req_ack),
    .result_base_addr (result_base_addr),
    .wr_almost_full   (wr_almost_full),
    .wr_req_valid     (wr_req_valid),
    .wr_req_addr      (wr_req_addr),
    .wr_req_data      (wr_req_data),
    .batch_done       (batch_done),
    .busy             (busy)
  );

  function automatic logic [DW-1:0] mkData(input int k, input logic [7:0] idx);
    logic [31:0] w;
    w = {8'(k), idx, 16'hA5C3};
    return {16{w}};
  endfunction

  // Buffer model: each buffer advances its line index on every ack it receives.
  logic [7:0] lineCnt [NPE];
  logic       feedLoad;
  logic [7:0] feedVal;

  always @(posedge clk) begin
    for (int k = 0; k < NPE; k++) begin
      if (feedLoad)            lineCnt[k] <= feedVal;
      else if (rbb_req_ack[k]) lineCnt[k] <= lineCnt[k] + 8'd1;
    end
  end

  for (genvar gk = 0; gk < NPE; gk++) begin : g_feed
    assign rbb_req_line_idx[gk*LW +: LW] = lineCnt[gk];
    assign rbb_req_data[gk*DW +: DW]     = mkData(gk, lineCnt[gk]);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Ack/valid coherence on every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      nAssert++;
      if ($countones(rbb_req_ack) > 1 || ((|rbb_req_ack) != wr_req_valid)) begin
        nFail++;
        $display("FAIL ack_coherence: ack=%b valid=%b", rbb_req_ack, wr_req_valid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitPulse(input int maxCyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < maxCyc && !ok) begin
      step();
      cyc++;
      ok = wr_req_valid;
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_wr_valid"}, wr_req_valid, 0);
    chk({tag, "_ack"}, rbb_req_ack, 0);
    chk({tag, "_batch_done"}, batch_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, wr_req_addr, 0);
    chk({tag, "_data"}, wr_req_data, 0);
  endtask

  task automatic doReset(input logic [7:0] startLine);
    reset            = 1'b1;
    rbb_req_valid    = '0;
    wr_almost_full   = 1'b0;
    result_base_addr = '0;
    feedLoad         = 1'b1;
    feedVal          = startLine;
    step();
    step();
    checkAllZero("reset");
    reset    = 1'b0;
    feedLoad = 1'b0;
  endtask

  // Collects one full 256-line batch from buffer g; firstLat of 0 skips the latency check.
  task automatic runBatch(input int g, input logic [31:0] base, input int firstLat);
    int cyc;
    bit ok;
    logic [3:0] expAck;
    expAck = 4'(1 << g);
    for (int n = 0; n < 256; n++) begin
      waitPulse(10, cyc, ok);
      chk("batch_pulse_seen", ok, 1);
      if (!ok) return;
      if (n == 0) begin
        if (firstLat > 0) chk("first_latency", cyc, firstLat);
      end else begin
        chk("line_spacing", cyc, 3);
      end
      chk("batch_ack", rbb_req_ack, expAck);
      chk("batch_addr", wr_req_addr, base + 32'(g << 8) + 32'(n));
      chk("batch_data", wr_req_data, mkData(g, 8'(n)));
      chk("batch_done", batch_done, (n == 255) ? expAck : 4'b0);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] base;
    int          expG;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int  cyc;
    bit  ok;
    int  pulses;
    logic [3:0] expAck;

    // Single-line batches (line 0xFF) so each vector completes and advances the pointer.
    vecs[0] = '{4'b0001, 32'h0000_1000, 0, 32'h0000_10FF};
    vecs[1] = '{4'b1010, 32'h0000_2000, 1, 32'h0000_21FF};
    vecs[2] = '{4'b1010, 32'h0000_2000, 3, 32'h0000_23FF};
    vecs[3] = '{4'b1111, 32'h0000_0000, 0, 32'h0000_00FF};
    vecs[4] = '{4'b0001, 32'hFFFF_FF00, 0, 32'hFFFF_FFFF};
    vecs[5] = '{4'b0100, 32'h1234_5678, 2, 32'h1234_5977};
    vecs[6] = '{4'b0110, 32'h0000_0000, 1, 32'h0000_01FF};

    doReset(8'h00);
    for (int v = 0; v < 7; v++) begin
      feedLoad = 1'b1;
      feedVal  = 8'hFF;
      step();
      feedLoad         = 1'b0;
      rbb_req_valid    = vecs[v].valid;
      result_base_addr = vecs[v].base;
      expAck           = 4'(1 << vecs[v].expG);
      waitPulse(10, cyc, ok);
      chk("vec_pulse_seen", ok, 1);
      chk("vec_latency", cyc, 2);
      chk("vec_ack", rbb_req_ack, expAck);
      chk("vec_addr", wr_req_addr, vecs[v].expAddr);
      chk("vec_data", wr_req_data, mkData(vecs[v].expG, 8'hFF));
      chk("vec_batch_done", batch_done, expAck);
      rbb_req_valid = '0;
      step();
      chk("vec_addr_hold", wr_req_addr, vecs[v].expAddr);
      chk("vec_data_hold", wr_req_data, mkData(vecs[v].expG, 8'hFF));
      step();
      step();
      chk("vec_busy_after", busy, 0);
    end

    // Full single-buffer batch.
    doReset(8'h00);
    result_base_addr = 32'h1000;
    rbb_req_valid    = 4'b0001;
    runBatch(0, 32'h1000, 2);
    rbb_req_valid = '0;
    step(); step(); step();
    chk("single_busy_end", busy, 0);

    // Contention: buffer 1 drains fully before buffer 3, then pointer returns to 0.
    doReset(8'h00);
    result_base_addr = 32'h4000;
    rbb_req_valid    = 4'b1010;
    runBatch(1, 32'h4000, 2);
    runBatch(3, 32'h4000, 0);
    rbb_req_valid = '0;
    step(); step(); step();
    rbb_req_valid = 4'b1010;
    waitPulse(10, cyc, ok);
    chk("contention_ptr_wrap_seen", ok, 1);
    chk("contention_ptr_wrap_ack", rbb_req_ack, 4'b0010);

    // Backpressure for 10 cycles after line 0 of buffer 2.
    doReset(8'h00);
    rbb_req_valid = 4'b0100;
    waitPulse(10, cyc, ok);
    chk("bp_first_seen", ok, 1);
    chk("bp_first_addr", wr_req_addr, 32'h200);
    wr_almost_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stalled_valid", wr_req_valid, 0);
      chk("bp_stalled_ack", rbb_req_ack, 0);
    end
    wr_almost_full = 1'b0;
    step();
    chk("bp_resume_valid", wr_req_valid, 1);
    chk("bp_resume_addr", wr_req_addr, 32'h201);
    waitPulse(10, cyc, ok);
    chk("bp_next_spacing", cyc, 3);
    chk("bp_next_addr", wr_req_addr, 32'h202);

    // Address wrap, then grant held while the granted buffer's valid is low.
    doReset(8'h80);
    result_base_addr = 32'hFFFF_FF80;
    rbb_req_valid    = 4'b0001;
    waitPulse(10, cyc, ok);
    chk("wrap_seen", ok, 1);
    chk("wrap_addr", wr_req_addr, 32'h0);
    chk("wrap_batch_done", batch_done, 0);
    rbb_req_valid = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wr_req_valid) pulses++;
    end
    chk("hold_no_pulse", pulses, 0);
    chk("hold_busy", busy, 1);
    rbb_req_valid = 4'b0011;
    waitPulse(10, cyc, ok);
    chk("hold_resume_ack", rbb_req_ack, 4'b0001);
    chk("hold_resume_addr", wr_req_addr, 32'h1);

    // Reset during the gap after line 37, then restart on buffer 2.
    doReset(8'h00);
    rbb_req_valid = 4'b0001;
    for (int n = 0; n <= 37; n++) waitPulse(10, cyc, ok);
    chk("rst_line37_addr", wr_req_addr, 32'd37);
    step();
    #3 reset = 1'b1;
    #1 checkAllZero("midreset");
    rbb_req_valid = 4'b0100;
    step();
    step();
    reset = 1'b0;
    waitPulse(10, cyc, ok);
    chk("rst_restart_latency", cyc, 2);
    chk("rst_restart_ack", rbb_req_ack, 4'b0100);
    chk("rst_restart_addr", wr_req_addr, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
